// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, addresses the instruction ROM, fills IF/ID.
// Ports: clk/rst_n, rom_addr/rom_inst, id_ready, redirect_*, halt_req,
//   id_inst/id_pc/id_valid to decode, halted and fetch_count status.
module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int CNT_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt_req,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [INST_W-1:0] inst_n;
  logic [ADDR_W-1:0] ipc_n;
  logic              valid_n;
  logic [CNT_W-1:0]  cnt_n;

  assign rom_addr = pc;
  assign halted   = (state == HALTED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      id_inst     <= '0;
      id_pc       <= '0;
      id_valid    <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      id_inst     <= inst_n;
      id_pc       <= ipc_n;
      id_valid    <= valid_n;
      fetch_count <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    inst_n  = id_inst;
    ipc_n   = id_pc;
    valid_n = id_valid;
    cnt_n   = fetch_count;
    if (redirect_valid) begin
      // squash IF/ID; target is fetched on the next edge
      state_n = RUN;
      pc_n    = redirect_addr;
      inst_n  = '0;
      valid_n = 1'b0;
    end else if (halt_req || state == HALTED) begin
      state_n = HALTED;
      valid_n = 1'b0;
    end else if (!id_ready && id_valid) begin
      state_n = HOLD;
    end else begin
      // an empty IF/ID fills even when decode is not ready
      state_n = RUN;
      inst_n  = rom_inst;
      ipc_n   = pc;
      valid_n = 1'b1;
      pc_n    = pc + PC_ONE;
      cnt_n   = fetch_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: fetch, stall, redirect, halt, wrap, reset.
// ROM model returns address+100; a second instance starts at all-ones.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_addr, rom_inst;
  logic        id_ready, redirect_valid, halt_req;
  logic [31:0] redirect_addr;
  logic [31:0] id_inst, id_pc;
  logic        id_valid, halted;
  logic [15:0] fetch_count;

  logic [31:0] rom_addr2, rom_inst2, id_inst2, id_pc2;
  logic        id_valid2, halted2;
  logic [15:0] fetch_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_inst  = rom_addr + 32'd100;
  assign rom_inst2 = rom_addr2 + 32'd100;

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .rom_addr(rom_addr), .rom_inst(rom_inst),
    .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halt_req(halt_req),
    .id_inst(id_inst), .id_pc(id_pc), .id_valid(id_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .rom_addr(rom_addr2), .rom_inst(rom_inst2),
    .id_ready(1'b1),
    .redirect_valid(1'b0), .redirect_addr(32'd0),
    .halt_req(1'b0),
    .id_inst(id_inst2), .id_pc(id_pc2), .id_valid(id_valid2),
    .halted(halted2), .fetch_count(fetch_count2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc,
                         input logic [31:0] inst, input logic [31:0] ipc,
                         input logic v, input logic h,
                         input logic [31:0] cnt);
    chk({tag, ".rom_addr"}, rom_addr, pc);
    chk({tag, ".id_inst"}, id_inst, inst);
    chk({tag, ".id_pc"}, id_pc, ipc);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, v});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
    chk({tag, ".count"}, {16'd0, fetch_count}, cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = 32'd0;
    halt_req = 1'b0;
    step();
    step();
    chk_all("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);

    // sequential fetch, edges 1..4
    rst_n = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      step();
      chk_all("seq", n, n + 99, n - 1, 1'b1, 1'b0, n);
      if (n == 1) begin
        chk("wrap.rom_addr", rom_addr2, 32'd0);
        chk("wrap.id_pc", id_pc2, 32'hFFFF_FFFF);
        chk("wrap.id_inst", id_inst2, 32'd99);
      end
    end

    // stall 4 cycles at id_pc=3
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all("stall", 32'd4, 32'd103, 32'd3, 1'b1, 1'b0, 32'd4);
    end
    id_ready = 1'b1;
    step();
    chk_all("unstall", 32'd5, 32'd104, 32'd4, 1'b1, 1'b0, 32'd5);

    // advance to pc=10
    for (int i = 0; i < 5; i++) step();
    chk_all("pc10", 32'd10, 32'd109, 32'd9, 1'b1, 1'b0, 32'd10);

    // redirect to 4
    redirect_valid = 1'b1;
    redirect_addr = 32'd4;
    step();
    chk_all("redir", 32'd4, 32'd0, 32'd9, 1'b0, 1'b0, 32'd10);
    redirect_valid = 1'b0;
    step();
    chk_all("redir.tgt", 32'd5, 32'd104, 32'd4, 1'b1, 1'b0, 32'd11);

    // redirect during stall; empty IF/ID fills despite id_ready=0
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    step();
    chk_all("redir.stall", 32'd4, 32'd0, 32'd4, 1'b0, 1'b0, 32'd11);
    redirect_valid = 1'b0;
    step();
    chk_all("fill.empty", 32'd5, 32'd104, 32'd4, 1'b1, 1'b0, 32'd12);
    id_ready = 1'b1;

    // branch skip: branch at 7, redirect to 9
    for (int i = 0; i < 3; i++) step();
    chk_all("br.at7", 32'd8, 32'd107, 32'd7, 1'b1, 1'b0, 32'd15);
    redirect_valid = 1'b1;
    redirect_addr = 32'd9;
    step();
    chk_all("br.skip", 32'd9, 32'd0, 32'd7, 1'b0, 1'b0, 32'd15);
    redirect_valid = 1'b0;
    step();
    chk_all("br.tgt", 32'd10, 32'd109, 32'd9, 1'b1, 1'b0, 32'd16);

    // halt at pc=6
    redirect_valid = 1'b1;
    redirect_addr = 32'd6;
    step();
    redirect_valid = 1'b0;
    halt_req = 1'b1;
    step();
    chk_all("halt", 32'd6, 32'd0, 32'd9, 1'b0, 1'b1, 32'd16);
    halt_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      id_ready = i[0];
      step();
      chk_all("halted", 32'd6, 32'd0, 32'd9, 1'b0, 1'b1, 32'd16);
    end
    id_ready = 1'b1;

    // redirect beats halt_req and resumes at 0
    redirect_valid = 1'b1;
    redirect_addr = 32'd0;
    halt_req = 1'b1;
    step();
    chk_all("resume", 32'd0, 32'd0, 32'd9, 1'b0, 1'b0, 32'd16);
    redirect_valid = 1'b0;
    halt_req = 1'b0;
    step();
    chk_all("resume.tgt", 32'd1, 32'd100, 32'd0, 1'b1, 1'b0, 32'd17);

    // reset mid-stall
    id_ready = 1'b0;
    step();
    chk_all("pre.rst", 32'd1, 32'd100, 32'd0, 1'b1, 1'b0, 32'd17);
    rst_n = 1'b0;
    step();
    chk_all("rst.stall", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("rst.wrap.pc", rom_addr2, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
